// File: rtl/pipeline_types.sv
// Shared pipeline types: the decoded-instruction entry carried from decode to dispatch.
package pipeline_types;

    localparam int unsigned IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] imm;
        logic [7:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fu_sel;
        logic [5:0]  flags;
    } decode_entry_t;

    localparam int unsigned IQ_ENTRY_W = $bits(decode_entry_t);

endpackage

// File: rtl/iq_ram_2w2r.sv
// Entry storage for the decode/dispatch queue: two write ports, two asynchronous read ports.
module iq_ram_2w2r
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH = IQ_DEPTH,
    parameter int unsigned WIDTH = IQ_ENTRY_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [AW-1:0]    raddr0,
    output logic [WIDTH-1:0] rdata0,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write addresses are always distinct (wr_ptr and wr_ptr+1), so port order is irrelevant.
    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/decode_dispatch_queue.sv
// Dual-issue in-order queue between decode and dispatch; accepts up to 2 and presents the 2 oldest.
module decode_dispatch_queue
    import pipeline_types::*;
#(
    parameter int unsigned DEPTH   = IQ_DEPTH,
    parameter int unsigned ENTRY_W = IQ_ENTRY_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 pause,
    input  logic [1:0]           enq_valid,
    input  logic [2*ENTRY_W-1:0] enq_data,
    output logic                 enq_ready,
    output logic [1:0]           deq_valid,
    output logic [2*ENTRY_W-1:0] deq_data,
    input  logic [1:0]           deq_ack
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_enq;
    logic [1:0]    n_enq, n_ack, n_deq;

    logic [ENTRY_W-1:0] slot0, slot1, wdata0, rdata0, rdata1;

    assign slot0 = enq_data[ENTRY_W-1:0];
    assign slot1 = enq_data[2*ENTRY_W-1:ENTRY_W];

    // Ready comes from registered count only; no credit for a same-cycle dequeue.
    assign enq_ready = count_q <= CW'(DEPTH - 2);
    assign deq_valid = {count_q >= CW'(2), count_q >= CW'(1)};

    always_comb begin
        do_enq = enq_ready && !flush && !rst;
        n_enq  = do_enq ? ({1'b0, enq_valid[0]} + {1'b0, enq_valid[1]}) : 2'd0;
        n_ack  = (pause || deq_ack == 2'd3) ? 2'd0 : deq_ack;
        // Over-ack is a protocol error; clamp so count can never underflow.
        n_deq  = (CW'(n_ack) > count_q) ? count_q[1:0] : n_ack;
        wr_ptr_d = wr_ptr_q + PW'(n_enq);
        rd_ptr_d = rd_ptr_q + PW'(n_deq);
        count_d  = count_q + CW'(n_enq) - CW'(n_deq);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // A lone slot-1 instruction is compacted down to wr_ptr.
    assign wdata0 = enq_valid[0] ? slot0 : slot1;

    iq_ram_2w2r #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk    (clk),
        .we0    (do_enq && (|enq_valid)),
        .waddr0 (wr_ptr_q),
        .wdata0 (wdata0),
        .we1    (do_enq && (&enq_valid)),
        .waddr1 (wr_ptr_q + PW'(1)),
        .wdata1 (slot1),
        .raddr0 (rd_ptr_q),
        .rdata0 (rdata0),
        .raddr1 (rd_ptr_q + PW'(1)),
        .rdata1 (rdata1)
    );

    assign deq_data = {rdata1, rdata0};

    a_enq_not_ready: assert property (@(posedge clk) disable iff (rst)
        !((|enq_valid) && !enq_ready));
    a_ack_three: assert property (@(posedge clk) disable iff (rst)
        deq_ack != 2'd3);
    a_ack_over: assert property (@(posedge clk) disable iff (rst)
        deq_ack <= ({1'b0, deq_valid[0]} + {1'b0, deq_valid[1]}));

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Directed self-checking bench for decode_dispatch_queue (DEPTH=8, 128-bit entries).
module tb_decode_dispatch_queue;

    logic         clk = 1'b0;
    logic         rst, flush, pause;
    logic [1:0]   enq_valid, deq_valid, deq_ack;
    logic [255:0] enq_data, deq_data;
    logic         enq_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_dispatch_queue dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pause     (pause),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ack   (deq_ack)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int t);
        return {32'hD0C0_0000 | 32'(t), ~32'(t), 32'(t * 3 + 1), 32'h5EED_0000 + 32'(t)};
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] v, input int t0, input int t1);
        enq_valid = v;
        enq_data  = {mk(t1), mk(t0)};
    endtask

    task automatic expect_q(input string tag, input logic [1:0] v, input int t0, input int t1);
        check_eq({tag, ".valid"}, 128'(deq_valid), 128'(v));
        if (v[0]) check_eq({tag, ".d0"}, deq_data[127:0], mk(t0));
        if (v[1]) check_eq({tag, ".d1"}, deq_data[255:128], mk(t1));
    endtask

    task automatic expect_ready(input string tag, input logic r);
        check_eq({tag, ".ready"}, 128'(enq_ready), 128'(r));
    endtask

    task automatic kill_midstream(input string tag, input logic use_rst);
        drive(2'b11, 10, 11); step();
        drive(2'b11, 12, 13); step();
        drive(2'b01, 14, 0);  step();
        drive(2'b00, 0, 0);
        expect_q({tag, ".pre"}, 2'b11, 10, 11);
        expect_ready({tag, ".pre"}, 1'b1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        drive(2'b11, 6, 7);
        deq_ack = 2'd2;
        step();
        rst = 1'b0; flush = 1'b0; deq_ack = 2'd0;
        drive(2'b00, 0, 0);
        expect_q({tag, ".post"}, 2'b00, 0, 0);
        expect_ready({tag, ".post"}, 1'b1);
        step();
        expect_q({tag, ".idle"}, 2'b00, 0, 0);
        drive(2'b11, 8, 9); step();
        drive(2'b00, 0, 0);
        expect_q({tag, ".new"}, 2'b11, 8, 9);
        deq_ack = 2'd2; step();
        deq_ack = 2'd0;
        expect_q({tag, ".drain"}, 2'b00, 0, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pause = 1'b0; deq_ack = 2'd0;
        drive(2'b00, 0, 0);
        @(negedge clk);
        step();
        rst = 1'b0;

        // 1: reset then idle
        for (int i = 0; i < 5; i++) begin
            expect_q("idle", 2'b00, 0, 0);
            expect_ready("idle", 1'b1);
            step();
        end

        // 2: basic pass A=1, B=2
        drive(2'b11, 1, 2); step();
        drive(2'b00, 0, 0);
        expect_q("basic", 2'b11, 1, 2);
        deq_ack = 2'd2; step();
        deq_ack = 2'd0;
        expect_q("basic.empty", 2'b00, 0, 0);

        // 3: compaction (C=3 in slot1) then D=4, E=5 with single acks
        drive(2'b10, 0, 3); step();
        expect_q("cmp.c", 2'b01, 3, 0);
        drive(2'b11, 4, 5); deq_ack = 2'd1; step();
        drive(2'b00, 0, 0);
        expect_q("cmp.de", 2'b11, 4, 5);
        step();
        expect_q("cmp.e", 2'b01, 5, 0);
        step();
        deq_ack = 2'd0;
        expect_q("cmp.empty", 2'b00, 0, 0);

        // 4: fill under pause
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_ready("fill", 1'b1);
            drive(2'b11, 100 + 2 * i, 101 + 2 * i);
            step();
        end
        drive(2'b00, 0, 0);
        expect_ready("full", 1'b0);
        expect_q("full", 2'b11, 100, 101);
        deq_ack = 2'd2; step();
        expect_ready("paused.ack", 1'b0);
        expect_q("paused.ack", 2'b11, 100, 101);
        pause = 1'b0; step();
        deq_ack = 2'd0;
        expect_ready("release", 1'b1);
        expect_q("release", 2'b11, 102, 103);
        deq_ack = 2'd2; step();
        expect_q("drain1", 2'b11, 104, 105);
        step();
        expect_q("drain2", 2'b11, 106, 107);
        step();
        deq_ack = 2'd0;
        expect_q("drain3", 2'b00, 0, 0);

        // 5: wrap-around, tags 200..239 streamed two per cycle
        drive(2'b11, 200, 201); step();
        for (int c = 1; c < 20; c++) begin
            expect_q("wrap", 2'b11, 200 + 2 * c - 2, 200 + 2 * c - 1);
            drive(2'b11, 200 + 2 * c, 201 + 2 * c);
            deq_ack = 2'd2;
            step();
        end
        drive(2'b00, 0, 0);
        expect_q("wrap.last", 2'b11, 238, 239);
        step();
        deq_ack = 2'd0;
        expect_q("wrap.empty", 2'b00, 0, 0);

        // 6: flush then reset mid-stream
        kill_midstream("flush", 1'b0);
        kill_midstream("rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
